// File: rtl/ex_reg_pkg.sv
// rtl/ex_reg_pkg.sv - shared pipeline widths, ID/EX field bundle and bubble constant
package ex_reg_pkg;

  localparam int XLEN          = 64;
  localparam int INST_W        = 32;
  localparam int ALU_OP_W      = 17;
  localparam int SEL_RFRES_W   = 2;
  localparam int MASK_W        = 4;
  localparam int SEL_ALURES_W  = 4;
  localparam int SEL_MEMDATA_W = 2;
  localparam int REG_ADDR_W    = 5;

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [INST_W-1:0]        inst;
    logic [ALU_OP_W-1:0]      alu_op;
    logic [SEL_RFRES_W-1:0]   sel_rfres;
    logic                     mem_wen;
    logic                     mem_ena;
    logic [MASK_W-1:0]        mem_mask;
    logic [SEL_ALURES_W-1:0]  sel_alures;
    logic [XLEN-1:0]          alu_src1;
    logic [XLEN-1:0]          alu_src2;
    logic [XLEN-1:0]          rf_rdata2;
    logic [SEL_MEMDATA_W-1:0] sel_memdata;
    logic                     rf_we;
    logic [REG_ADDR_W-1:0]    rf_waddr;
    logic                     sys;
    logic                     load;
  } pipe_fields_t;

  // All-zero bubble clears every side-effect bit (rf_we, mem_ena, mem_wen, sys, load).
  localparam pipe_fields_t BUBBLE = '0;

endpackage

// File: rtl/ex_reg_if.sv
// rtl/ex_reg_if.sv - ID-to-EX stage register bus with control, id_* and ex_* fields
interface ex_reg_if import ex_reg_pkg::*; ;

  logic                     valid;
  logic                     ena;

  logic [XLEN-1:0]          id_pc,          ex_pc;
  logic [INST_W-1:0]        id_inst,        ex_inst;
  logic [ALU_OP_W-1:0]      id_alu_op,      ex_alu_op;
  logic [SEL_RFRES_W-1:0]   id_sel_rfres,   ex_sel_rfres;
  logic                     id_mem_wen,     ex_mem_wen;
  logic                     id_mem_ena,     ex_mem_ena;
  logic [MASK_W-1:0]        id_mem_mask,    ex_mem_mask;
  logic [SEL_ALURES_W-1:0]  id_sel_alures,  ex_sel_alures;
  logic [XLEN-1:0]          id_alu_src1,    ex_alu_src1;
  logic [XLEN-1:0]          id_alu_src2,    ex_alu_src2;
  logic [XLEN-1:0]          id_rf_rdata2,   ex_rf_rdata2;
  logic [SEL_MEMDATA_W-1:0] id_sel_memdata, ex_sel_memdata;
  logic                     id_rf_we,       ex_rf_we;
  logic [REG_ADDR_W-1:0]    id_rf_waddr,    ex_rf_waddr;
  logic                     id_sys,         ex_sys;
  logic                     id_load,        ex_load;

  modport master (
    output valid, ena,
    output id_pc, id_inst, id_alu_op, id_sel_rfres, id_mem_wen, id_mem_ena,
           id_mem_mask, id_sel_alures, id_alu_src1, id_alu_src2, id_rf_rdata2,
           id_sel_memdata, id_rf_we, id_rf_waddr, id_sys, id_load,
    input  ex_pc, ex_inst, ex_alu_op, ex_sel_rfres, ex_mem_wen, ex_mem_ena,
           ex_mem_mask, ex_sel_alures, ex_alu_src1, ex_alu_src2, ex_rf_rdata2,
           ex_sel_memdata, ex_rf_we, ex_rf_waddr, ex_sys, ex_load
  );

  modport slave (
    input  valid, ena,
    input  id_pc, id_inst, id_alu_op, id_sel_rfres, id_mem_wen, id_mem_ena,
           id_mem_mask, id_sel_alures, id_alu_src1, id_alu_src2, id_rf_rdata2,
           id_sel_memdata, id_rf_we, id_rf_waddr, id_sys, id_load,
    output ex_pc, ex_inst, ex_alu_op, ex_sel_rfres, ex_mem_wen, ex_mem_ena,
           ex_mem_mask, ex_sel_alures, ex_alu_src1, ex_alu_src2, ex_rf_rdata2,
           ex_sel_memdata, ex_rf_we, ex_rf_waddr, ex_sys, ex_load
  );

endinterface

// File: rtl/ex_reg_pipe_dff.sv
// rtl/ex_reg_pipe_dff.sv - pipeline flop with sync reset value, hold enable and bubble load
module pipe_dff #(
  parameter int               WIDTH      = 1,
  parameter logic [WIDTH-1:0] RST_VAL    = '0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             valid,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  // Priority: rst > hold (ena=0) > bubble (valid=0) > capture.
  always_comb begin
    q_d = q_q;
    if (ena) begin
      q_d = valid ? d : BUBBLE_VAL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RST_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/ex_reg.sv
// rtl/ex_reg.sv - ID/EX pipeline register: one pipe_dff per field, outputs straight from flops
module ex_reg import ex_reg_pkg::*; (
  input  logic     clk,
  input  logic     rst,
  ex_reg_if.slave  bus
);

  pipe_dff #(.WIDTH(XLEN), .BUBBLE_VAL(BUBBLE.pc)) u_pc (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_pc), .q(bus.ex_pc));

  pipe_dff #(.WIDTH(INST_W), .BUBBLE_VAL(BUBBLE.inst)) u_inst (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_inst), .q(bus.ex_inst));

  pipe_dff #(.WIDTH(ALU_OP_W), .BUBBLE_VAL(BUBBLE.alu_op)) u_alu_op (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_alu_op), .q(bus.ex_alu_op));

  pipe_dff #(.WIDTH(SEL_RFRES_W), .BUBBLE_VAL(BUBBLE.sel_rfres)) u_sel_rfres (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_sel_rfres),
    .q(bus.ex_sel_rfres));

  pipe_dff #(.WIDTH(1), .BUBBLE_VAL(BUBBLE.mem_wen)) u_mem_wen (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_mem_wen), .q(bus.ex_mem_wen));

  pipe_dff #(.WIDTH(1), .BUBBLE_VAL(BUBBLE.mem_ena)) u_mem_ena (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_mem_ena), .q(bus.ex_mem_ena));

  pipe_dff #(.WIDTH(MASK_W), .BUBBLE_VAL(BUBBLE.mem_mask)) u_mem_mask (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_mem_mask),
    .q(bus.ex_mem_mask));

  pipe_dff #(.WIDTH(SEL_ALURES_W), .BUBBLE_VAL(BUBBLE.sel_alures)) u_sel_alures (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_sel_alures),
    .q(bus.ex_sel_alures));

  pipe_dff #(.WIDTH(XLEN), .BUBBLE_VAL(BUBBLE.alu_src1)) u_alu_src1 (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_alu_src1),
    .q(bus.ex_alu_src1));

  pipe_dff #(.WIDTH(XLEN), .BUBBLE_VAL(BUBBLE.alu_src2)) u_alu_src2 (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_alu_src2),
    .q(bus.ex_alu_src2));

  pipe_dff #(.WIDTH(XLEN), .BUBBLE_VAL(BUBBLE.rf_rdata2)) u_rf_rdata2 (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_rf_rdata2),
    .q(bus.ex_rf_rdata2));

  pipe_dff #(.WIDTH(SEL_MEMDATA_W), .BUBBLE_VAL(BUBBLE.sel_memdata)) u_sel_memdata (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_sel_memdata),
    .q(bus.ex_sel_memdata));

  // rf_waddr travels untouched next to rf_we; x0 writes are filtered downstream.
  pipe_dff #(.WIDTH(1), .BUBBLE_VAL(BUBBLE.rf_we)) u_rf_we (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_rf_we), .q(bus.ex_rf_we));

  pipe_dff #(.WIDTH(REG_ADDR_W), .BUBBLE_VAL(BUBBLE.rf_waddr)) u_rf_waddr (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_rf_waddr),
    .q(bus.ex_rf_waddr));

  pipe_dff #(.WIDTH(1), .BUBBLE_VAL(BUBBLE.sys)) u_sys (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_sys), .q(bus.ex_sys));

  pipe_dff #(.WIDTH(1), .BUBBLE_VAL(BUBBLE.load)) u_load (
    .clk(clk), .rst(rst), .ena(bus.ena), .valid(bus.valid), .d(bus.id_load), .q(bus.ex_load));

endmodule

// File: tb/tb_ex_reg.sv
// tb/tb_ex_reg.sv - randomized self-checking bench for ex_reg against a behavioural model
module tb_ex_reg;
  import ex_reg_pkg::*;

  localparam int CW = $bits(pipe_fields_t);

  logic clk = 1'b0;
  logic rst;

  ex_reg_if bus ();

  ex_reg dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  pipe_fields_t cur_in;
  pipe_fields_t exp_q;
  logic [XLEN-1:0] pc_hist[$];

  task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic pipe_fields_t rand_fields();
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[i*32 +: 32] = $urandom;
    return r[CW-1:0];
  endfunction

  task automatic drive(input pipe_fields_t f);
    cur_in              = f;
    bus.id_pc           = f.pc;
    bus.id_inst         = f.inst;
    bus.id_alu_op       = f.alu_op;
    bus.id_sel_rfres    = f.sel_rfres;
    bus.id_mem_wen      = f.mem_wen;
    bus.id_mem_ena      = f.mem_ena;
    bus.id_mem_mask     = f.mem_mask;
    bus.id_sel_alures   = f.sel_alures;
    bus.id_alu_src1     = f.alu_src1;
    bus.id_alu_src2     = f.alu_src2;
    bus.id_rf_rdata2    = f.rf_rdata2;
    bus.id_sel_memdata  = f.sel_memdata;
    bus.id_rf_we        = f.rf_we;
    bus.id_rf_waddr     = f.rf_waddr;
    bus.id_sys          = f.sys;
    bus.id_load         = f.load;
  endtask

  function automatic pipe_fields_t observed();
    pipe_fields_t o;
    o.pc          = bus.ex_pc;
    o.inst        = bus.ex_inst;
    o.alu_op      = bus.ex_alu_op;
    o.sel_rfres   = bus.ex_sel_rfres;
    o.mem_wen     = bus.ex_mem_wen;
    o.mem_ena     = bus.ex_mem_ena;
    o.mem_mask    = bus.ex_mem_mask;
    o.sel_alures  = bus.ex_sel_alures;
    o.alu_src1    = bus.ex_alu_src1;
    o.alu_src2    = bus.ex_alu_src2;
    o.rf_rdata2   = bus.ex_rf_rdata2;
    o.sel_memdata = bus.ex_sel_memdata;
    o.rf_we       = bus.ex_rf_we;
    o.rf_waddr    = bus.ex_rf_waddr;
    o.sys         = bus.ex_sys;
    o.load        = bus.ex_load;
    return o;
  endfunction

  // Stage-register rules: reset clears, disable holds, invalid loads a bubble, else capture.
  function automatic pipe_fields_t model_next(input logic r, input logic e, input logic v,
                                              input pipe_fields_t in, input pipe_fields_t cur);
    if (r) return '0;
    if (!e) return cur;
    if (!v) return '0;
    return in;
  endfunction

  task automatic cycle();
    pipe_fields_t nxt;
    nxt = model_next(rst, bus.ena, bus.valid, cur_in, exp_q);
    @(posedge clk);
    #1;
    exp_q = nxt;
  endtask

  initial begin
    pipe_fields_t f;
    exp_q = '0;

    // Reset with every input forced high
    rst = 1'b1; bus.ena = 1'b1; bus.valid = 1'b1;
    drive('1);
    cycle();
    cycle();
    check("reset_all", observed(), '0);
    check("reset_sys", CW'(bus.ex_sys), CW'(1'b0));
    check("reset_rf_we", CW'(bus.ex_rf_we), CW'(1'b0));

    // Directed capture: addi x1, x0, 10
    rst = 1'b0;
    f = '0;
    f.pc = 64'h8000_0004; f.inst = 32'h00A0_0093; f.rf_we = 1'b1; f.rf_waddr = 5'd1;
    f.alu_src1 = 64'd0; f.alu_src2 = 64'd10;
    drive(f);
    cycle();
    check("capture_all", observed(), exp_q);
    check("capture_pc", CW'(bus.ex_pc), CW'(64'h8000_0004));
    check("capture_inst", CW'(bus.ex_inst), CW'(32'h00A0_0093));
    check("capture_src2", CW'(bus.ex_alu_src2), CW'(64'd10));

    // Hold for three cycles while inputs churn
    f = rand_fields(); f.pc = 64'h8000_0010;
    drive(f);
    cycle();
    check("hold_load_pc", CW'(bus.ex_pc), CW'(64'h8000_0010));
    bus.ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.valid = 1'($urandom);
      drive(rand_fields());
      cycle();
      check("hold_pc", CW'(bus.ex_pc), CW'(64'h8000_0010));
      check("hold_all", observed(), exp_q);
    end

    // Bubble with side-effect bits set on the input
    bus.ena = 1'b1; bus.valid = 1'b0;
    f = rand_fields(); f.load = 1'b1; f.mem_ena = 1'b1; f.rf_we = 1'b1;
    drive(f);
    cycle();
    check("bubble_all", observed(), '0);

    // x0 destination passes through unchanged with rf_we
    bus.valid = 1'b1;
    f = rand_fields(); f.rf_waddr = 5'd0; f.rf_we = 1'b1;
    drive(f);
    cycle();
    check("waddr0_all", observed(), CW'(f));

    // Reset beats hold, then sys is visible exactly one cycle
    rst = 1'b1; bus.ena = 1'b0;
    drive(rand_fields());
    cycle();
    check("prio_reset", observed(), '0);
    rst = 1'b0; bus.ena = 1'b1; bus.valid = 1'b1;
    f = rand_fields(); f.sys = 1'b1;
    drive(f);
    cycle();
    check("prio_sys_on", CW'(bus.ex_sys), CW'(1'b1));
    f = rand_fields(); f.sys = 1'b0;
    drive(f);
    cycle();
    check("prio_sys_off", CW'(bus.ex_sys), CW'(1'b0));

    // Streaming: 8 back-to-back distinct PCs
    for (int i = 0; i < 8; i++) begin
      f = rand_fields(); f.pc = 64'h8000_1000 + 64'(i * 4);
      pc_hist.push_back(f.pc);
      drive(f);
      cycle();
      check("stream_pc", CW'(bus.ex_pc), CW'(pc_hist.pop_front()));
    end

    // Random mix of reset, hold, bubble and capture
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 15) == 0);
      bus.ena   = ($urandom_range(0, 3) != 0);
      bus.valid = ($urandom_range(0, 3) != 0);
      drive(rand_fields());
      cycle();
      check("random_all", observed(), exp_q);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_reg.md
EX_REG -- requirements
Module: ex_reg

Interface
REQ-001 Parameters: none; all widths fixed as listed below.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 valid  input  1  1 = ID-stage contents are a real instruction; 0 = load a bubble.
REQ-005 ena  input  1  register update enable; 0 = hold all outputs.
REQ-006 id_pc input 64 / ex_pc output 64  instruction PC.
REQ-007 id_inst input 32 / ex_inst output 32  raw instruction word.
REQ-008 id_alu_op input 17 / ex_alu_op output 17  one-hot ALU operation.
REQ-009 id_sel_rfres input 2 / ex_sel_rfres output 2  register-file write-data source select.
REQ-010 id_mem_wen input 1 / ex_mem_wen output 1  memory write enable.
REQ-011 id_mem_ena input 1 / ex_mem_ena output 1  memory access enable.
REQ-012 id_mem_mask input 4 / ex_mem_mask output 4  memory access size/byte mask code.
REQ-013 id_sel_alures input 4 / ex_sel_alures output 4  ALU result post-processing select.
REQ-014 id_alu_src1 input 64 / ex_alu_src1 output 64  ALU operand 1, already forwarded.
REQ-015 id_alu_src2 input 64 / ex_alu_src2 output 64  ALU operand 2, already forwarded.
REQ-016 id_rf_rdata2 input 64 / ex_rf_rdata2 output 64  store data (rs2 value).
REQ-017 id_sel_memdata input 2 / ex_sel_memdata output 2  load-data extension select.
REQ-018 id_rf_we input 1 / ex_rf_we output 1  register-file write enable.
REQ-019 id_rf_waddr input 5 / ex_rf_waddr output 5  destination register index.
REQ-020 id_sys input 1 / ex_sys output 1  ebreak/system-stop marker.
REQ-021 id_load input 1 / ex_load output 1  instruction is a load; used for load-use hazard detection.

Function
REQ-022 Every ex_* output SHALL be a plain flop output, with no combinational path from any input.
REQ-023 On a rising clk with rst=0, ena=1 and valid=1, each ex_* output SHALL take its id_* input value; latency is exactly 1 cycle.
REQ-024 On a rising clk with rst=0, ena=1 and valid=0, all ex_* outputs SHALL become 0 (bubble).
REQ-025 A bubble SHALL have ex_rf_we=0, ex_mem_ena=0, ex_mem_wen=0, ex_sys=0 and ex_load=0, so it has no architectural side effect.
REQ-026 On a rising clk with rst=0 and ena=0, all outputs SHALL hold their previous values regardless of valid and id_*.
REQ-027 Priority SHALL be rst > ena=0 (hold) > valid=0 (bubble) > capture.
REQ-028 No field SHALL be modified, sign-extended or gated when captured; id_rf_waddr=0 SHALL pass unchanged with its ex_rf_we.
REQ-029 Back-to-back captures on consecutive cycles SHALL each be visible for exactly one cycle; there are no internal buffers or skid.

Reset
REQ-030 While rst=1 at a rising edge, every ex_* output SHALL be 0 on the next cycle, regardless of ena and valid.
REQ-031 Reset asserted mid-stream SHALL discard the held instruction; the first capture after deassertion SHALL follow REQ-023.
REQ-032 Before the first clock edge, output values SHALL be don't-care; reset SHALL be applied for at least one cycle.

Structure
REQ-033 A shared pipeline package SHALL hold the width constants: XLEN=64, INST_W=32, ALU_OP_W=17, SEL_RFRES_W=2, MASK_W=4, SEL_ALURES_W=4, SEL_MEMDATA_W=2, REG_ADDR_W=5.
REQ-034 The package SHALL hold the bubble value (all-zero) as a named constant.
REQ-035 One sub-module is natural: pipe_dff, a width-parameterised flop with synchronous reset value, enable, and bubble-load, instantiated once per field.
REQ-036 The ID/IF and EX/MEM, MEM/WB stage registers SHALL reuse pipe_dff with the same rst/ena/valid semantics.

Verification
REQ-037 Reset check: rst=1 for 2 cycles with all id_* = all-ones -> every ex_* = 0, including ex_sys=0 and ex_rf_we=0.
REQ-038 Capture check: rst=0, ena=1, valid=1, id_pc=0x80000004, id_inst=0x00A00093, id_rf_we=1, id_rf_waddr=1, id_alu_src1=0, id_alu_src2=10 -> next cycle the ex_* outputs equal exactly those values.
REQ-039 Hold check: capture id_pc=0x80000010, then ena=0 for 3 cycles while id_* changes randomly -> ex_pc stays 0x80000010 and all other outputs are unchanged.
REQ-040 Bubble check: ena=1, valid=0 with id_load=1, id_mem_ena=1, id_rf_we=1 -> next cycle all outputs = 0.
REQ-041 Priority check: rst=1 with ena=0 -> outputs cleared; then rst=0, ena=1, valid=1, id_sys=1 -> ex_sys=1 exactly one cycle later.
REQ-042 Streaming check: 8 consecutive captures of distinct id_pc values -> ex_pc reproduces the sequence delayed by exactly 1 cycle.
